// File: rtl/pixel_pkg.sv
// pixel_pkg: pixel field layout, hue constants, sector enum and saturating add shared by hsv2rgb
package pixel_pkg;
  localparam int H_W = 9;
  localparam int S_W = 7;
  localparam int V_W = 8;
  localparam int H_LSB = 15;
  localparam int S_LSB = 8;
  localparam int V_LSB = 0;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  localparam logic [8:0] HUE_MAX = 9'd360;
  localparam logic [8:0] SECTOR_DEG = 9'd60;
  localparam logic [10:0] RECIP60 = 11'd1093;
  typedef enum logic [2:0] {SEC0, SEC1, SEC2, SEC3, SEC4, SEC5} sector_e;
  function automatic logic [7:0] add_sat(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[8] ? 8'hFF : t[7:0];
  endfunction
endpackage

// File: rtl/hsv2rgb_if.sv
// hsv2rgb_if: pixel stream in/out of hsv2rgb; master drives en/valid_in/pixel_in/pass_in, slave returns valid_out/pixel_out/pass_thru
interface hsv2rgb_if #(parameter int PASS_W = 24);
  logic en;
  logic valid_in;
  logic [23:0] pixel_in;
  logic [PASS_W-1:0] pass_in;
  logic valid_out;
  logic [23:0] pixel_out;
  logic [PASS_W-1:0] pass_thru;
  modport master(output en, valid_in, pixel_in, pass_in, input valid_out, pixel_out, pass_thru);
  modport slave(input en, valid_in, pixel_in, pass_in, output valid_out, pixel_out, pass_thru);
endinterface

// File: rtl/hue_sector.sv
// hue_sector: combinational hue -> (sector, offset in sector); H >= 360 wraps under HSV2RGB_HUE_WRAP_EN, else becomes 0
module hue_sector
  import pixel_pkg::*;
(
  input  logic [H_W-1:0] h,
  output sector_e        sector,
  output logic [5:0]     r
);
  logic [H_W-1:0] hn;
`ifdef HSV2RGB_HUE_WRAP_EN
  assign hn = h >= HUE_MAX ? h - HUE_MAX : h;
`else
  assign hn = h >= HUE_MAX ? '0 : h;
`endif
  assign sector = hn < SECTOR_DEG ? SEC0 :
                  hn < 9'(2 * SECTOR_DEG) ? SEC1 :
                  hn < 9'(3 * SECTOR_DEG) ? SEC2 :
                  hn < 9'(4 * SECTOR_DEG) ? SEC3 :
                  hn < 9'(5 * SECTOR_DEG) ? SEC4 : SEC5;
  assign r = 6'(hn - SECTOR_DEG * 9'(sector));
endmodule

// File: rtl/hsv2rgb.sv
// hsv2rgb: 3-stage HSV->RGB pipeline with en bypass and side-band pass-through; hue wrap via HSV2RGB_HUE_WRAP_EN
module hsv2rgb
  import pixel_pkg::*;
#(
  parameter int PASS_W = 24
) (
  input logic      clk,
  input logic      rst_n,
  hsv2rgb_if.slave bus
);
  logic [S_W-1:0] s_in;
  logic [V_W-1:0] v_in;
  logic [7:0] s_eff, c_in;
  sector_e sec_in, sec1, sec2;
  logic [5:0] r_in, r1, k;
  logic v1, v2, e1, e2;
  logic [PASS_W-1:0] pass1, pass2;
  logic [23:0] px1, px2, rgb;
  logic [7:0] c1, m1, c2, m2, x2, x_raw, x;
  assign s_in = bus.pixel_in[S_LSB +: S_W];
  assign v_in = bus.pixel_in[V_LSB +: V_W];
  assign s_eff = s_in == 7'd127 ? 8'd128 : {1'b0, s_in};
  assign c_in = 8'(({8'd0, v_in} * {8'd0, s_eff}) >> 7);
  hue_sector u_hue (.h(bus.pixel_in[H_LSB +: H_W]), .sector(sec_in), .r(r_in));
  assign k = sec1[0] ? 6'(SECTOR_DEG) - r1 : r1;
  assign x_raw = 8'((24'(c1) * 24'(k) * 24'(RECIP60)) >> 16);
  assign x = x_raw > c1 ? c1 : x_raw;
  always_comb begin
    rgb = '0;
    rgb[R_LSB +: 8] = add_sat(m2, sec2 inside {SEC0, SEC5} ? c2 : sec2 inside {SEC1, SEC4} ? x2 : 8'd0);
    rgb[G_LSB +: 8] = add_sat(m2, sec2 inside {SEC1, SEC2} ? c2 : sec2 inside {SEC0, SEC3} ? x2 : 8'd0);
    rgb[B_LSB +: 8] = add_sat(m2, sec2 inside {SEC3, SEC4} ? c2 : sec2 inside {SEC2, SEC5} ? x2 : 8'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, e1, pass1, px1, c1, m1, r1} <= '0;
      {v2, e2, pass2, px2, c2, m2, x2} <= '0;
      sec1 <= SEC0;
      sec2 <= SEC0;
      bus.valid_out <= 1'b0;
      bus.pixel_out <= '0;
      bus.pass_thru <= '0;
    end else begin
      v1 <= bus.valid_in;
      e1 <= bus.en;
      pass1 <= bus.pass_in;
      px1 <= bus.pixel_in;
      c1 <= c_in;
      m1 <= v_in - c_in;
      sec1 <= sec_in;
      r1 <= r_in;
      v2 <= v1;
      e2 <= e1;
      pass2 <= pass1;
      px2 <= px1;
      c2 <= c1;
      m2 <= m1;
      x2 <= x;
      sec2 <= sec1;
      bus.valid_out <= v2;
      bus.pixel_out <= e2 ? rgb : px2;
      bus.pass_thru <= pass2;
    end
  end
endmodule

// File: tb/tb_hsv2rgb.sv
// tb_hsv2rgb: directed vectors with queued expectations checked by an independent output monitor
module tb_hsv2rgb;
  typedef struct {
    logic [23:0] pix;
    logic [23:0] pass;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [23:0] pass_ctr = 24'h000100;
  exp_t q[$];
  logic [23:0] vin[10];
  logic [23:0] vexp[10];
  hsv2rgb_if #(.PASS_W(24)) bus ();
  hsv2rgb #(.PASS_W(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [23:0] hsv(input int h, input int s, input int v);
    return {9'(h), 7'(s), 8'(v)};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic e, input logic [23:0] pix, input logic [23:0] exp);
    @(posedge clk);
    #1;
    bus.en = e;
    bus.valid_in = 1'b1;
    bus.pixel_in = pix;
    bus.pass_in = pass_ctr;
    q.push_back('{exp, pass_ctr, cyc});
    pass_ctr++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.pixel_in = 24'hA5A5A5;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask
  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_pixel_out"}, 32'(bus.pixel_out), 32'd0);
    check({tag, "_pass_thru"}, 32'(bus.pass_thru), 32'd0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.valid_out) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pixel_out %h with nothing pending", bus.pixel_out);
        end else begin
          e = q.pop_front();
          check("pixel_out", 32'(bus.pixel_out), 32'(e.pix));
          check("pass_thru", 32'(bus.pass_thru), 32'(e.pass));
          check("latency", 32'(cyc - e.t), 32'd3);
        end
      end
    end
  end
  initial begin
    vin[0] = hsv(0, 127, 255);   vexp[0] = 24'hFF0000;
    vin[1] = hsv(120, 127, 255); vexp[1] = 24'h00FF00;
    vin[2] = hsv(240, 127, 255); vexp[2] = 24'h0000FF;
    vin[3] = hsv(60, 127, 255);  vexp[3] = 24'hFFFF00;
    vin[4] = hsv(0, 0, 128);     vexp[4] = 24'h808080;
    vin[5] = hsv(359, 127, 255); vexp[5] = 24'hFF0004;
    vin[6] = hsv(30, 64, 200);   vexp[6] = 24'hC89664;
    vin[7] = hsv(200, 100, 128); vexp[7] = 24'h1C5E80;
    vin[8] = hsv(300, 127, 255); vexp[8] = 24'hFF00FF;
`ifdef HSV2RGB_HUE_WRAP_EN
    vin[9] = hsv(400, 127, 255); vexp[9] = 24'hFFAA00;
`else
    vin[9] = hsv(400, 127, 255); vexp[9] = 24'hFF0000;
`endif
    bus.en = 1'b1;
    bus.valid_in = 1'b0;
    bus.pixel_in = '0;
    bus.pass_in = '0;
    repeat (2) @(posedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.valid_in = 1'b1;
    bus.pixel_in = vin[0];
    bus.pass_in = pass_ctr;
    q.push_back('{vexp[0], pass_ctr, cyc});
    pass_ctr++;
    for (int i = 1; i < 10; i++) send(1'b1, vin[i], vexp[i]);
    send(1'b1, hsv(200, 0, 128), 24'h808080);
    send(1'b1, hsv(40, 127, 255), 24'hFFAA00);
    send(1'b0, 24'h123456, 24'h123456);
    idle(2);
    drain();
    for (int i = 0; i < 10; i++) send(i < 5, vin[i], i < 5 ? vexp[i] : vin[i]);
    idle(1);
    drain();
    send(1'b1, vin[6], vexp[6]);
    send(1'b1, vin[7], vexp[7]);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    q.delete();
    check_reset_outputs("mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    send(1'b1, vin[3], vexp[3]);
    idle(2);
    drain();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hsv2rgb.md
HSV2RGB -- requirements
Module: hsv2rgb

Interface
REQ-001 SHALL have parameter PASS_W, default 24: width of the side-band pass_in/pass_thru bus.
REQ-002 SHALL have port clk, input, 1: single clock; all registers rising-edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port en, input, 1: 1 = convert, 0 = bypass the pixel unchanged.
REQ-005 SHALL have port valid_in, input, 1: pixel_in/pass_in qualifier.
REQ-006 SHALL have port pixel_in, input, 24: HSV; [23:15] hue H, [14:8] saturation S, [7:0] value V.
REQ-007 SHALL have port pass_in, input, PASS_W: side-band data, carried unchanged.
REQ-008 SHALL have port valid_out, output, 1: pixel_out/pass_thru qualifier.
REQ-009 SHALL have port pixel_out, output, 24: RGB; [23:16] R, [15:8] G, [7:0] B.
REQ-010 SHALL have port pass_thru, output, PASS_W: pass_in delayed to match pixel_out.

Function
REQ-011 SHALL be a fixed 3-stage streaming pipeline, latency 3 cycles, throughput 1 pixel/cycle, no backpressure; all stages advance every cycle.
REQ-012 SHALL sample en, pixel_in, pass_in and valid_in together; en travels with its pixel, so an en change mid-stream affects only pixels sampled after it.
REQ-013 SHALL produce valid_out = valid_in delayed by 3 cycles; pixel_out and pass_thru are defined only while valid_out = 1.
REQ-014 SHALL, for bypassed pixels (en = 0), output pixel_in unchanged after 3 cycles.
REQ-015 Stage 1 SHALL compute S' = 128 if S = 127, else S; C = (V*S') >> 7, 8 bits; m = V - C.
REQ-016 Stage 1 SHALL normalise H >= 360 to 0 (see REQ-025); sector = H/60 (0..5); r = H - 60*sector (0..59).
REQ-017 Stage 2 SHALL compute k = r for even sectors and k = 60 - r for odd sectors, then X = (C*k*1093) >> 16, saturated to C.
REQ-018 Stage 3 SHALL select (R,G,B) by sector: 0:(C,X,0) 1:(X,C,0) 2:(0,C,X) 3:(0,X,C) 4:(X,0,C) 5:(C,0,X), then add m to each component.
REQ-019 Each output component SHALL saturate at 255.
REQ-020 S = 0 SHALL yield R = G = B = V for any H.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear all pipeline registers; valid_out = 0, pixel_out = 0, pass_thru = 0.
REQ-022 SHALL discard all in-flight pixels when reset asserts mid-stream; none appear after release.
REQ-023 SHALL, after rst_n rises, present the first valid_out exactly 3 cycles after the first sampled valid_in = 1.

Configuration
REQ-024 SHALL be controlled by macro HSV2RGB_HUE_WRAP_EN.
REQ-025 With HSV2RGB_HUE_WRAP_EN defined, H >= 360 SHALL be replaced by H - 360. Without it, H >= 360 SHALL be treated as 0. Latency is unchanged in both cases.

Structure
REQ-026 Shared package pixel_pkg SHALL hold: HSV field widths and offsets, RGB field offsets, HUE_MAX = 360, SECTOR_DEG = 60, RECIP60 = 1093, and a sector enum (SEC0..SEC5).
REQ-027 SHALL instantiate sub-module hue_sector (combinational: H -> sector, r, including the wrap/zero rule); all registers stay in hsv2rgb.

Verification
REQ-028 Reset: rst_n low, then high with valid_in = 1 -> valid_out = 0 and outputs 0 for 3 cycles, first valid result on the 4th edge.
REQ-029 Primaries: H=0,S=127,V=255 -> 0xFF0000; H=120 -> 0x00FF00; H=240 -> 0x0000FF; H=60 -> 0xFFFF00; all with latency 3.
REQ-030 Grey/bypass: S=0,V=0x80 -> 0x808080. en=0, pixel_in 0x123456 -> 0x123456 after 3 cycles, with pass_in aligned.
REQ-031 Hue boundaries: H=359,S=127,V=255 -> R=255,G=0,B=4. H=400 -> 0xFF0000 without HSV2RGB_HUE_WRAP_EN; with it, as H=40 -> 0xFFAA00.
REQ-032 Stream/reset: 10 back-to-back valid pixels with en toggling on pixel 5 -> per-pixel correct mode, no gaps. Reset asserted after pixel 2 -> no stale outputs after release.
